// File: rtl/peripheral_mpram_ahb3_ctrl.sv
// -----------------------------------------------------------------------------
// peripheral_mpram_ahb3_ctrl
//
// AHB3-Lite slave front-end for the MPRAM peripheral. Converts bus transfers
// into accesses on a single-port 16-bit RAM macro with low-active controls and
// a one-cycle registered read. Checks transfer size, alignment and range, and
// encodes byte lanes. A read that arrives while the write data phase owns the
// RAM port is held for one wait state (RDW).
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL, HADDR, HWRITE,
//   HSIZE, HTRANS, HREADY AHB address-phase inputs
//   HWDATA               AHB write data (data phase)
//   HRDATA, HREADYOUT,
//   HRESP                AHB slave response
//   ram_addr             RAM word address
//   ram_cen              RAM chip enable, low active
//   ram_wen              RAM byte write enables, low active ([0] -> bits 7:0)
//   ram_din              RAM write data
//   ram_dout             RAM read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module peripheral_mpram_ahb3_ctrl #(
  parameter int HADDR_SIZE = 32,
  parameter int ADDR_MSB   = 6,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [15:0]           HWDATA,
  output logic [15:0]           HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_MSB:0]     ram_addr,
  output logic                  ram_cen,
  output logic [15:0]           ram_din,
  output logic [1:0]            ram_wen,
  input  logic [15:0]           ram_dout
);

  // Number of 16-bit words, sized to the full halfword address for the range check.
  localparam logic [HADDR_SIZE-2:0] NUM_WORDS = (HADDR_SIZE-1)'(MEM_SIZE / 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDW,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_MSB:0]   addr_reg,  addr_next;
  logic [1:0]          wen_reg,   wen_next;

  logic                hready_out;
  logic                accept;
  logic                illegal;
  logic [ADDR_MSB:0]   word_addr;
  logic [1:0]          lanes;

  // HTRANS[0] only distinguishes NONSEQ from SEQ, which this slave treats alike.
  logic                unused_htrans;
  assign unused_htrans = HTRANS[0];

  // Only RDW and ERR1 stretch the data phase.
  assign hready_out = (state_reg != ST_RDW) && (state_reg != ST_ERR1);
  assign HREADYOUT  = hready_out;

  assign accept    = HSEL && HREADY && HTRANS[1] && hready_out;
  assign word_addr = HADDR[ADDR_MSB+1:1];

  // Range is checked on the whole halfword address so bits above the RAM
  // word address cannot alias back into the array.
  assign illegal = (HSIZE > 3'd1)
                || ((HSIZE == 3'd1) && HADDR[0])
                || (HADDR[HADDR_SIZE-1:1] >= NUM_WORDS);

  // Low-active byte enables: halfword writes both lanes, byte picks by HADDR[0].
  assign lanes = (HSIZE == 3'd1) ? 2'b00 : (HADDR[0] ? 2'b01 : 2'b10);

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      wen_reg   <= 2'b11;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wen_reg   <= wen_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wen_next   = wen_reg;
    case (state_reg)
      ST_RDW:  state_next = ST_RD;
      ST_ERR1: state_next = ST_ERR2;
      default: begin
        if (!accept) begin
          state_next = ST_IDLE;
        end else if (illegal) begin
          state_next = ST_ERR1;
        end else if (HWRITE) begin
          state_next = ST_WR;
          addr_next  = word_addr;
          wen_next   = lanes;
        end else if (state_reg == ST_WR) begin
          // Port is busy with the write data phase: replay the read next cycle.
          state_next = ST_RDW;
          addr_next  = word_addr;
        end else begin
          state_next = ST_RD;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    HRESP    = 1'b0;
    HRDATA   = '0;
    ram_cen  = 1'b1;
    ram_wen  = 2'b11;
    ram_addr = addr_reg;
    ram_din  = '0;
    case (state_reg)
      ST_WR: begin
        ram_cen = 1'b0;
        ram_wen = wen_reg;
        ram_din = HWDATA;
      end
      ST_RDW: begin
        ram_cen = 1'b0;
      end
      ST_RD: begin
        HRDATA = ram_dout;
      end
      ST_ERR1, ST_ERR2: begin
        HRESP = 1'b1;
      end
      default: ;
    endcase
    // Zero-wait read: issue the RAM read straight from the address phase
    // whenever the port is not taken by a write data phase.
    if ((state_reg != ST_WR) && accept && !illegal && !HWRITE) begin
      ram_cen  = 1'b0;
      ram_wen  = 2'b11;
      ram_addr = word_addr;
    end
  end

endmodule

// File: tb/tb_peripheral_mpram_ahb3_ctrl.sv
module tb_peripheral_mpram_ahb3_ctrl;

  localparam int HADDR_SIZE = 32;
  localparam int ADDR_MSB   = 6;
  localparam int MEM_SIZE   = 256;

  logic                  HCLK = 1'b0;
  logic                  HRESETn;
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [15:0]           HWDATA;
  logic [15:0]           HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [ADDR_MSB:0]     ram_addr;
  logic                  ram_cen;
  logic [15:0]           ram_din;
  logic [1:0]            ram_wen;
  logic [15:0]           ram_dout;

  peripheral_mpram_ahb3_ctrl #(
    .HADDR_SIZE(HADDR_SIZE),
    .ADDR_MSB  (ADDR_MSB),
    .MEM_SIZE  (MEM_SIZE)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .ram_addr (ram_addr),
    .ram_cen  (ram_cen),
    .ram_din  (ram_din),
    .ram_wen  (ram_wen),
    .ram_dout (ram_dout)
  );

  always #5 HCLK = ~HCLK;

  // Single slave on the bus: HREADY follows this slave.
  assign HREADY = HREADYOUT;

  // RAM macro model: low-active enables, registered read.
  logic [15:0] mem [0:127];
  int          access_cnt = 0;
  always @(posedge HCLK) begin
    if (!ram_cen) begin
      if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
      if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      ram_dout   <= mem[ram_addr];
      access_cnt <= access_cnt + 1;
    end
  end

  typedef struct packed {
    logic        is_rd;
    logic [15:0] data;
    logic        resp;
    logic [7:0]  waits;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    fails  = 0;
  logic [15:0] wdata_pend = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: tracks the data phase of each accepted transfer and compares it
  // against the scoreboard entry pushed when the transfer was issued.
  initial begin
    logic dp_active;
    int   waits;
    exp_t e;
    dp_active = 1'b0;
    waits     = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_active = 1'b0;
        waits     = 0;
        exp_q.delete();
        name_q.delete();
      end else begin
        if (dp_active) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard: data phase with no expected entry");
            dp_active = 1'b0;
          end else begin
            e = exp_q[0];
            check({name_q[0], " hresp"}, 32'(HRESP), 32'(e.resp));
            if (HREADYOUT) begin
              if (e.is_rd) check({name_q[0], " hrdata"}, 32'(HRDATA), 32'(e.data));
              check({name_q[0], " waits"}, 32'(waits), 32'(e.waits));
              $display("txn %-10s rd=%0d hrdata=%h hresp=%0d waits=%0d",
                       name_q[0], e.is_rd, HRDATA, HRESP, waits);
              void'(exp_q.pop_front());
              void'(name_q.pop_front());
            end else begin
              waits++;
            end
          end
        end
        if (HREADYOUT) begin
          dp_active = HSEL && HTRANS[1];
          waits     = 0;
        end
      end
    end
  end

  // Wait for the address phase on the bus to be sampled with HREADY high.
  task automatic wait_ready(input string nm);
    logic rdy;
    int   n;
    n = 0;
    do begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      @(posedge HCLK);
      #1;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      checks++;
      fails++;
      $display("FAIL %s: HREADYOUT stuck low, got 0, expected 1 within 20 cycles", nm);
    end
  endtask

  task automatic xfer(input string nm, input logic sel, input logic [1:0] trans,
                      input logic wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [15:0] wdata, input logic [15:0] exp_data,
                      input logic exp_resp, input int exp_waits);
    exp_t e;
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
    HWDATA = wdata_pend;
    if (sel && trans[1]) begin
      e.is_rd = !wr;
      e.data  = exp_data;
      e.resp  = exp_resp;
      e.waits = 8'(exp_waits);
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    wait_ready(nm);
    wdata_pend = wdata;
  endtask

  task automatic idle();
    xfer("idle", 1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 16'h0, 16'h0, 1'b0, 0);
  endtask

  task automatic wr16(input string nm, input logic [31:0] a, input logic [15:0] d);
    xfer(nm, 1'b1, 2'b10, 1'b1, 3'd1, a, d, 16'h0, 1'b0, 0);
  endtask

  task automatic rd16(input string nm, input logic [31:0] a, input logic [15:0] d, input int w);
    xfer(nm, 1'b1, 2'b10, 1'b0, 3'd1, a, 16'h0, d, 1'b0, w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt0;
    HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = '0; HWDATA = '0;
    #12;
    check("rst hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst hresp",     32'(HRESP),     32'd0);
    check("rst hrdata",    32'(HRDATA),    32'h0);
    check("rst ram_cen",   32'(ram_cen),   32'd1);
    check("rst ram_wen",   32'(ram_wen),   32'h3);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    idle();

    // Write then read of the same address: read stalls one cycle in RDW.
    wr16("wr04", 32'h04, 16'hBEEF);
    rd16("rd04", 32'h04, 16'hBEEF, 1);
    idle();

    // Byte write of the upper lane over 0xBEEF at word 3.
    wr16("wr06", 32'h06, 16'hBEEF);
    xfer("wrb07", 1'b1, 2'b10, 1'b1, 3'd0, 32'h07, 16'h12AB, 16'h0, 1'b0, 0);
    check("wrb07 ram_wen", 32'(ram_wen), 32'h1);
    check("wrb07 ram_cen", 32'(ram_cen), 32'd0);
    rd16("rd06", 32'h06, 16'h12EF, 1);
    idle();

    // Preload, then four back-to-back zero-wait reads.
    wr16("pre00", 32'h00, 16'h1111);
    wr16("pre02", 32'h02, 16'h2222);
    wr16("pre04", 32'h04, 16'h3333);
    wr16("pre06", 32'h06, 16'h4444);
    idle();
    rd16("rd00", 32'h00, 16'h1111, 0);
    rd16("rd02", 32'h02, 16'h2222, 0);
    rd16("rd04b", 32'h04, 16'h3333, 0);
    rd16("rd06b", 32'h06, 16'h4444, 0);
    idle();
    idle();

    // Illegal transfers: two-cycle ERROR, no RAM access.
    cnt0 = access_cnt;
    xfer("err_size", 1'b1, 2'b10, 1'b0, 3'd2, 32'h00, 16'h0, 16'h0, 1'b1, 1);
    idle();
    xfer("err_align", 1'b1, 2'b10, 1'b1, 3'd1, 32'h01, 16'h5555, 16'h0, 1'b1, 1);
    idle();
    xfer("err_range", 1'b1, 2'b10, 1'b0, 3'd1, 32'h100, 16'h0, 16'h0, 1'b1, 1);
    idle();
    idle();
    check("err ram accesses", 32'(access_cnt), 32'(cnt0));

    // IDLE with HSEL, and NONSEQ without HSEL: zero-wait OKAY, no access.
    cnt0 = access_cnt;
    xfer("idle_sel", 1'b1, 2'b00, 1'b0, 3'd1, 32'h00, 16'h0, 16'h0, 1'b0, 0);
    check("idle_sel hreadyout", 32'(HREADYOUT), 32'd1);
    check("idle_sel hresp",     32'(HRESP),     32'd0);
    xfer("nosel", 1'b0, 2'b10, 1'b0, 3'd1, 32'h02, 16'h0, 16'h0, 1'b0, 0);
    check("nosel hreadyout", 32'(HREADYOUT), 32'd1);
    check("nosel hresp",     32'(HRESP),     32'd0);
    idle();
    check("idle ram accesses", 32'(access_cnt), 32'(cnt0));

    // Reset in the middle of a write data phase discards the write.
    wr16("wr04c", 32'h04, 16'h1234);
    idle();
    wr16("wr04rst", 32'h04, 16'hDEAD);
    HWDATA = 16'hDEAD;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HRESETn = 1'b0;
    #1;
    check("midwr hreadyout", 32'(HREADYOUT), 32'd1);
    check("midwr hresp",     32'(HRESP),     32'd0);
    check("midwr ram_cen",   32'(ram_cen),   32'd1);
    check("midwr ram_wen",   32'(ram_wen),   32'h3);
    @(posedge HCLK); #1;
    HRESETn    = 1'b1;
    wdata_pend = '0;
    idle();
    rd16("rd04rst", 32'h04, 16'h1234, 0);
    idle();
    idle();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/peripheral_mpram_ahb3_ctrl.md
Name: peripheral_mpram_ahb3_ctrl

Overview:
AHB3-Lite slave front-end that converts bus transfers into the single-port, 16-bit, low-active RAM macro interface (ram_cen/ram_wen/ram_addr/ram_din/ram_dout, one-cycle registered read) of the MPRAM peripheral. It sits directly upstream of the RAM macro, between the interconnect and the memory.
- Handles byte-lane selection, range and size checking.
- Resolves the write-data-phase vs read-address-phase port conflict by inserting wait states.

Parameters:
HADDR_SIZE, 32, AHB address width
ADDR_MSB, 6, MSB of RAM word address (ram_addr width = ADDR_MSB+1)
MEM_SIZE, 256, RAM size in bytes; valid word addresses 0..MEM_SIZE/2-1

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  byte address
HWDATA  in  16  write data (data phase)
HRDATA  out  16  read data
HWRITE  in  1  1=write
HSIZE  in  3  0=byte, 1=halfword, others illegal
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HREADY  in  1  bus ready (previous transfer done)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
ram_addr  out  ADDR_MSB+1  RAM word address
ram_cen  out  1  RAM chip enable, low active
ram_din  out  16  RAM write data
ram_wen  out  2  RAM byte write enable, low active
ram_dout  in  16  RAM read data, valid the cycle after a read access

Behaviour:
- Reset (async, HRESETn=0):
  - State = IDLE; HREADYOUT=1; HRESP=0; HRDATA=0.
  - ram_cen=1, ram_wen=2'b11.
  - Any pending write or stalled read is discarded; no RAM access occurs.
- Accept condition: an address phase is accepted when HSEL & HREADY & HTRANS[1]. IDLE/BUSY transfers get a zero-wait OKAY and cause no RAM access.
- Word address: HADDR[ADDR_MSB+1:1]. Lane select: HADDR[0].
- Error check, done at accept. A transfer is illegal if any of:
  - HSIZE>1;
  - HSIZE=1 with HADDR[0]=1;
  - word address >= MEM_SIZE/2.
  An illegal transfer goes to ERR1 and never touches the RAM.
- Lane encoding, ram_wen:
  - halfword = 2'b00;
  - byte, HADDR[0]=0 = 2'b10 (write [7:0]);
  - byte, HADDR[0]=1 = 2'b01 (write [15:8]);
  - read = 2'b11.
- States:
  - IDLE: no data phase pending.
  - WR: write data phase.
    - Drive ram_cen=0, ram_addr=latched address, ram_din=HWDATA, ram_wen=latched lanes.
    - HREADYOUT=1. The write completes at the end of this cycle.
  - RD: read data phase.
    - HREADYOUT=1, HRDATA=ram_dout.
  - RDW: stalled read, entered when a read is accepted while the port is busy with a WR data phase.
    - Drive ram_cen=0, ram_wen=2'b11, ram_addr=latched address.
    - HREADYOUT=0, HRDATA=0. Next state = RD.
  - ERR1: HRESP=1, HREADYOUT=0. Next state = ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. Next state follows the accept rules below.
- Transitions, evaluated at every cycle with HREADYOUT=1:
  - Accepted read, when the current state is not WR: drive ram_cen=0, ram_wen=2'b11, ram_addr=word address combinationally in the address phase, then go to RD. This gives zero wait states.
  - Accepted read while in WR: latch the address, go to RDW. This costs exactly one wait state.
  - Accepted write: latch address and lanes, go to WR.
  - Accepted illegal transfer: go to ERR1.
  - No accept: go to IDLE.
- During RDW, ERR1 or any HREADYOUT=0 cycle: no new address phase is accepted (HREADY is low on the bus).
- ram_cen=1 and ram_wen=2'b11 in every cycle without an access.
- Back-to-back writes: every cycle is a WR data phase; no stalls.
- Back-to-back reads: one read per cycle, zero wait.
- Byte reads return the full halfword; the master selects the lane.
- Write then read of the same address (read stalled into RDW) returns the newly written data.

Test Plan:
- Reset: HRESETn=0 mid-WR -> HREADYOUT=1, HRESP=0, ram_cen=1, ram_wen=2'b11 immediately; memory at that address unchanged.
- Halfword write 0xBEEF to 0x04, then halfword read 0x04 issued in the write data phase -> one cycle HREADYOUT=0 (RDW), then HRDATA=0xBEEF with OKAY.
- Byte write 0x12 to 0x07 over 0xBEEF at word 3 -> ram_wen=2'b01; a subsequent read of 0x06 returns 0x12EF.
- Four consecutive NONSEQ reads of 0x00,0x02,0x04,0x06 after preloading 0x1111,0x2222,0x3333,0x4444 -> HRDATA sequence 0x1111..0x4444 with HREADYOUT=1 every cycle.
- Illegal transfers: HSIZE=2; halfword at 0x01; address 0x100 with MEM_SIZE=256 -> each gets a two-cycle ERROR (HRESP=1; HREADYOUT 0 then 1) and ram_cen stays 1.
- HTRANS=IDLE with HSEL=1, and HSEL=0 with HTRANS=NONSEQ -> OKAY, zero wait, no RAM access.
